// File: rtl/slave_port_ctrl.sv
// ---------------------------------------------------------------------------
// slave_port_ctrl
//
// Serial slave port that turns a bit-serial bus into parallel memory
// accesses. A transaction starts with a beat in IDLE (smode selects write/
// read), then shifts ADDR_WIDTH address bits LSB first. A write then shifts
// DATA_WIDTH data bits and issues a single-cycle mem_wen. A read holds
// mem_ren until the memory stage answers with mem_rvalid, captures
// mem_rdata and returns it serially on srdata/srvalid, LSB first.
// Every output is driven straight from a register.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rstn        asynchronous active-low reset
//   svalid      bus beat valid (smode/swdata sampled only when high)
//   smode       1 = write, 0 = read (first beat only)
//   swdata      serial address / write-data bit, LSB first
//   sready      high only while idle; a transaction may start only then
//   srdata      serial read-data bit, LSB first
//   srvalid     high while srdata carries a read-data bit
//   mem_addr    address to the memory stage (held until next transaction)
//   mem_wdata   write data to the memory stage (held until next write)
//   mem_wen     one-cycle memory write enable
//   mem_ren     memory read enable, held until mem_rvalid
//   mem_rdata   memory read data, valid with mem_rvalid
//   mem_rvalid  memory read-data valid (ignored unless a read is pending)
// ---------------------------------------------------------------------------
module slave_port_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  svalid,
    input  logic                  smode,
    input  logic                  swdata,
    output logic                  sready,
    output logic                  srdata,
    output logic                  srvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    // The read-out phase counts up to DATA_WIDTH inclusive, hence MAX_W + 1.
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        MEMWR,
        MEMRD,
        RDATA
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_mode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_sready;
    logic                  r_srdata;
    logic                  r_srvalid;
    logic                  r_wen;
    logic                  r_ren;

    state_t                w_next_state;
    logic [CNT_W-1:0]      w_cnt;
    logic                  w_mode;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_srdata;
    logic                  w_srvalid;

    // State and all outputs are registered together so each output reflects
    // the state the FSM is in during that cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_sready  <= 1'b1;
            r_srdata  <= 1'b0;
            r_srvalid <= 1'b0;
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt;
            r_mode    <= w_mode;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_rdata   <= w_rdata;
            r_sready  <= (w_next_state == IDLE);
            r_srdata  <= w_srdata;
            r_srvalid <= w_srvalid;
            r_wen     <= (w_next_state == MEMWR);
            r_ren     <= (w_next_state == MEMRD);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt        = r_cnt;
        w_mode       = r_mode;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_rdata      = r_rdata;
        w_srdata     = 1'b0;
        w_srvalid    = 1'b0;

        case (r_state)
            IDLE: begin
                if (svalid) begin
                    w_mode    = smode;
                    w_addr[0] = swdata;
                    if (ADDR_WIDTH == 1) begin
                        w_cnt        = '0;
                        w_next_state = smode ? WDATA : MEMRD;
                    end else begin
                        w_cnt        = CNT_W'(1);
                        w_next_state = ADDR;
                    end
                end
            end

            ADDR: begin
                if (svalid) begin
                    // Decoded bit write keeps the index the same width as the counter.
                    for (int i = 0; i < ADDR_WIDTH; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            w_addr[i] = swdata;
                        end
                    end
                    if (r_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                        w_cnt        = '0;
                        w_next_state = r_mode ? WDATA : MEMRD;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end

            WDATA: begin
                if (svalid) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            w_wdata[i] = swdata;
                        end
                    end
                    if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        w_cnt        = '0;
                        w_next_state = MEMWR;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end

            MEMWR: begin
                w_next_state = IDLE;
            end

            MEMRD: begin
                // Bit 0 goes out on the capture edge so srvalid starts with RDATA.
                if (mem_rvalid) begin
                    w_rdata      = mem_rdata;
                    w_srvalid    = 1'b1;
                    w_srdata     = mem_rdata[0];
                    w_cnt        = CNT_W'(1);
                    w_next_state = RDATA;
                end
            end

            RDATA: begin
                // r_cnt is the index of the next bit to present; once it reaches
                // DATA_WIDTH all bits have been shown for one cycle each.
                if (r_cnt == CNT_W'(DATA_WIDTH)) begin
                    w_cnt        = '0;
                    w_next_state = IDLE;
                end else begin
                    w_srvalid = 1'b1;
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            w_srdata = r_rdata[i];
                        end
                    end
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_next_state = IDLE;
                w_cnt        = '0;
            end
        endcase
    end

    assign sready    = r_sready;
    assign srdata    = r_srdata;
    assign srvalid   = r_srvalid;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wen   = r_wen;
    assign mem_ren   = r_ren;

endmodule
